window_3x3_gen: RTL and testbench



---
 rtl/window_3x3_gen.sv | 162 ++++++++++++++++
 tb/tb_window_3x3_gen.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/window_3x3_gen.sv
// 3x3 neighbourhood generator for a raster, ce-qualified pixel stream.
// Two line buffers hold the previous rows; windows are emitted only for interior centres.
module window_3x3_gen #(
  parameter int WIDTH       = 11,
  parameter int BRAM_SIZE_W = 11,
  parameter int COORD_W     = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic                   sof,
  input  logic [WIDTH-1:0]       din,
  input  logic [BRAM_SIZE_W-1:0] h_size,
  input  logic [COORD_W-1:0]     v_size,
  output logic [9*WIDTH-1:0]     window,
  output logic                   window_valid,
  output logic [COORD_W-1:0]     cx,
  output logic [COORD_W-1:0]     cy,
  output logic                   frame_end
);

  localparam int                     DEPTH = 1 << BRAM_SIZE_W;
  localparam logic [BRAM_SIZE_W-1:0] XONE  = BRAM_SIZE_W'(1);
  localparam logic [BRAM_SIZE_W-1:0] XTWO  = BRAM_SIZE_W'(2);
  localparam logic [COORD_W-1:0]     YONE  = COORD_W'(1);
  localparam logic [COORD_W-1:0]     YTWO  = COORD_W'(2);

  // Input position counters
  logic [BRAM_SIZE_W-1:0] r_xi;
  logic [COORD_W-1:0]     r_yi;
  logic [BRAM_SIZE_W-1:0] w_px_x;
  logic [COORD_W-1:0]     w_px_y;
  logic                   w_last_x;
  logic                   w_last_y;

  // Line buffers and their registered read data
  logic [WIDTH-1:0] r_lb1 [0:DEPTH-1];
  logic [WIDTH-1:0] r_lb2 [0:DEPTH-1];
  logic [WIDTH-1:0] r_lb1_q;
  logic [WIDTH-1:0] r_lb2_q;

  // Stage 1: captured pixel and position
  logic                   r_s1_ce;
  logic [WIDTH-1:0]       r_s1_din;
  logic [BRAM_SIZE_W-1:0] r_s1_x;
  logic [COORD_W-1:0]     r_s1_y;
  logic                   r_s1_last;

  // Stage 2: window array r_col[column][row] and output qualifiers
  logic [WIDTH-1:0]   r_col [0:2][0:2];
  logic               r_s2_valid;
  logic               r_s2_fe;
  logic [COORD_W-1:0] r_s2_cx;
  logic [COORD_W-1:0] r_s2_cy;
  logic [9*WIDTH-1:0] w_win;

  // sof forces the current pixel to (0,0) before the counters are consulted
  always_comb begin
    w_px_x   = sof ? '0 : r_xi;
    w_px_y   = sof ? '0 : r_yi;
    w_last_x = (w_px_x == (h_size - XONE));
    w_last_y = (w_px_y == (v_size - YONE));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xi <= '0;
      r_yi <= '0;
    end else if (ce) begin
      if (w_last_x) begin
        r_xi <= '0;
        r_yi <= w_last_y ? '0 : (w_px_y + YONE);
      end else begin
        r_xi <= w_px_x + XONE;
        r_yi <= w_px_y;
      end
    end
  end

  // Read-before-write: LB2 inherits the row LB1 held at this column
  always_ff @(posedge clk) begin
    if (ce) begin
      r_lb1_q        <= r_lb1[w_px_x];
      r_lb2_q        <= r_lb2[w_px_x];
      r_lb1[w_px_x]  <= din;
      r_lb2[w_px_x]  <= r_lb1[w_px_x];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_ce   <= 1'b0;
      r_s1_din  <= '0;
      r_s1_x    <= '0;
      r_s1_y    <= '0;
      r_s1_last <= 1'b0;
    end else begin
      r_s1_ce <= ce;
      if (ce) begin
        r_s1_din  <= din;
        r_s1_x    <= w_px_x;
        r_s1_y    <= w_px_y;
        r_s1_last <= w_last_x && w_last_y;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned c = 0; c < 3; c++) begin
        for (int unsigned r = 0; r < 3; r++) begin
          r_col[c][r] <= '0;
        end
      end
      r_s2_valid <= 1'b0;
      r_s2_fe    <= 1'b0;
      r_s2_cx    <= '0;
      r_s2_cy    <= '0;
    end else begin
      r_s2_valid <= r_s1_ce && (r_s1_x >= XTWO) && (r_s1_y >= YTWO);
      r_s2_fe    <= r_s1_ce && r_s1_last;
      if (r_s1_ce) begin
        r_col[0]    <= r_col[1];
        r_col[1]    <= r_col[2];
        r_col[2][0] <= r_lb2_q;
        r_col[2][1] <= r_lb1_q;
        r_col[2][2] <= r_s1_din;
        r_s2_cx     <= COORD_W'(r_s1_x - XONE);
        r_s2_cy     <= r_s1_y - YONE;
      end
    end
  end

  always_comb begin
    w_win = '0;
    for (int unsigned r = 0; r < 3; r++) begin
      for (int unsigned c = 0; c < 3; c++) begin
        w_win[(3*r+c)*WIDTH +: WIDTH] = r_col[c][r];
      end
    end
  end

  // Output register holds the last emitted window between pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window       <= '0;
      window_valid <= 1'b0;
      cx           <= '0;
      cy           <= '0;
      frame_end    <= 1'b0;
    end else begin
      window_valid <= r_s2_valid;
      frame_end    <= r_s2_fe;
      if (r_s2_valid) begin
        window <= w_win;
        cx     <= r_s2_cx;
        cy     <= r_s2_cy;
      end
    end
  end

endmodule

// File: tb/tb_window_3x3_gen.sv
// Randomized bench for window_3x3_gen: a frame-store model predicts every window,
// centre and frame_end pulse with its exact arrival cycle.
module tb_window_3x3_gen;
  localparam int W  = 8;
  localparam int BW = 5;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ce  = 1'b0;
  logic          sof = 1'b0;
  logic [W-1:0]  din = '0;
  logic [BW-1:0] h_size = '0;
  logic [CW-1:0] v_size = '0;
  logic [9*W-1:0] window;
  logic          window_valid;
  logic [CW-1:0] cx;
  logic [CW-1:0] cy;
  logic          frame_end;

  window_3x3_gen #(.WIDTH(W), .BRAM_SIZE_W(BW), .COORD_W(CW)) dut (
    .clk(clk), .rst(rst), .ce(ce), .sof(sof), .din(din),
    .h_size(h_size), .v_size(v_size), .window(window),
    .window_valid(window_valid), .cx(cx), .cy(cy), .frame_end(frame_end)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int             t;
    logic [9*W-1:0] win;
    int             cx;
    int             cy;
  } exp_t;

  exp_t           wq[$];
  int             fq[$];
  logic [W-1:0]   img [0:255][0:31];
  int             mx = 0, my = 0, cur_h = 3, cur_v = 3;
  logic [9*W-1:0] last_win = '0;
  int             n_win = 0, n_fe = 0, last_cx = 0, last_cy = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    bit   ev;
    bit   ef;
    exp_t e;
    ev = (wq.size() > 0) && (wq[0].t == cyc);
    check("valid", window_valid, ev);
    if (ev) begin
      e = wq.pop_front();
      check("window", window, e.win);
      check("cx", cx, e.cx);
      check("cy", cy, e.cy);
      last_win = e.win;
    end else begin
      check("hold", window, last_win);
    end
    if (window_valid) begin
      n_win++;
      last_cx = cx;
      last_cy = cy;
    end
    ef = (fq.size() > 0) && (fq[0] == cyc);
    check("frame_end", frame_end, ef);
    if (ef) void'(fq.pop_front());
    if (frame_end) n_fe++;
  end

  // One input cycle; the frame-store model records every accepted pixel
  task automatic drive(input bit c, input bit s, input logic [W-1:0] d);
    int   x, y;
    exp_t e;
    @(negedge clk);
    ce = c; sof = s; din = d;
    if (c) begin
      x = s ? 0 : mx;
      y = s ? 0 : my;
      img[y][x] = d;
      if (x >= 2 && y >= 2) begin
        e.t = cyc + 3; e.cx = x - 1; e.cy = y - 1; e.win = '0;
        for (int r = 0; r < 3; r++)
          for (int k = 0; k < 3; k++)
            e.win[(3*r+k)*W +: W] = img[y-2+r][x-2+k];
        wq.push_back(e);
      end
      if (x == cur_h - 1 && y == cur_v - 1) fq.push_back(cyc + 3);
      if (x == cur_h - 1) begin
        mx = 0;
        my = (y == cur_v - 1) ? 0 : y + 1;
      end else begin
        mx = x + 1;
        my = y;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, W'($urandom));
  endtask

  task automatic set_size(input int h, input int v);
    cur_h = h; cur_v = v;
    h_size = BW'(h); v_size = CW'(v);
  endtask

  task automatic send_pixels(input int n, input bit sof_first, input int base,
                             input bit rnd, input int pct);
    logic [W-1:0] d;
    int x, y;
    for (int i = 0; i < n; i++) begin
      while (int'($urandom_range(99)) >= pct) drive(1'b0, 1'b0, W'($urandom));
      x = (i == 0 && sof_first) ? 0 : mx;
      y = (i == 0 && sof_first) ? 0 : my;
      d = rnd ? W'($urandom) : W'(base + 16*y + x);
      drive(1'b1, (i == 0) && sof_first, d);
    end
  endtask

  initial begin
    int w0, f0, h, v;
    set_size(5, 4);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_window", window, 0);
    check("rst_valid", window_valid, 0);
    check("rst_cx", cx, 0);
    check("rst_cy", cy, 0);
    check("rst_fe", frame_end, 0);
    @(negedge clk) rst = 1'b0;

    // Basic frame, continuous ce, din = 16*y + x
    w0 = n_win; f0 = n_fe;
    send_pixels(20, 1'b1, 0, 1'b0, 100);
    idle(5);
    check("basic_count", n_win - w0, 6);
    check("basic_last_cx", last_cx, 3);
    check("basic_last_cy", last_cy, 2);
    check("basic_fe", n_fe - f0, 1);

    // Same frame with ~40% ce density
    w0 = n_win;
    send_pixels(20, 1'b1, 0, 1'b0, 40);
    idle(5);
    check("gap_count", n_win - w0, 6);
    check("gap_last_cx", last_cx, 3);
    check("gap_last_cy", last_cy, 2);

    // Two frames back to back, second offset by 0x40
    w0 = n_win; f0 = n_fe;
    send_pixels(20, 1'b1, 0, 1'b0, 70);
    send_pixels(20, 1'b1, 'h40, 1'b0, 70);
    idle(5);
    check("b2b_count", n_win - w0, 12);
    check("b2b_fe", n_fe - f0, 2);

    // sof arriving at (3,2) resyncs the counters
    w0 = n_win;
    send_pixels(13, 1'b1, 0, 1'b0, 100);
    send_pixels(20, 1'b1, 'h80, 1'b0, 100);
    idle(5);
    check("resync_count", n_win - w0, 7);

    // Asynchronous reset mid-frame drops in-flight results
    send_pixels(12, 1'b1, 0, 1'b1, 100);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_window", window, 0);
    check("arst_valid", window_valid, 0);
    check("arst_cx", cx, 0);
    check("arst_fe", frame_end, 0);
    wq.delete(); fq.delete();
    last_win = '0; mx = 0; my = 0;
    @(negedge clk);
    rst = 1'b0; ce = 1'b0; sof = 1'b0;
    w0 = n_win;
    send_pixels(20, 1'b0, 0, 1'b1, 100);
    idle(5);
    check("after_rst_count", n_win - w0, 6);

    // Longest legal line
    set_size(31, 3);
    w0 = n_win;
    send_pixels(93, 1'b1, 0, 1'b1, 100);
    idle(5);
    check("maxline_count", n_win - w0, 29);
    check("maxline_last_cx", last_cx, 29);
    check("maxline_last_cy", last_cy, 1);

    // Random geometries, densities and data
    for (int f = 0; f < 4; f++) begin
      h = int'($urandom_range(31, 3));
      v = int'($urandom_range(8, 3));
      set_size(h, v);
      w0 = n_win;
      send_pixels(h * v, 1'b1, 0, 1'b1, int'($urandom_range(100, 30)));
      idle(5);
      check("rand_count", n_win - w0, (h - 2) * (v - 2));
    end

    check("drain_win", wq.size(), 0);
    check("drain_fe", fq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
